// File: rtl/core2axi_mo_if.sv
// rtl/core2axi_mo_if.sv - AXI4 master channel bundle used by core2axi_mo.
interface core2axi_mo_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int USER_W = 10
);
  logic [ID_W-1:0]     aw_id;
  logic [ADDR_W-1:0]   aw_addr;
  logic [7:0]          aw_len;
  logic [2:0]          aw_size;
  logic [1:0]          aw_burst;
  logic                aw_lock;
  logic [3:0]          aw_cache;
  logic [2:0]          aw_prot;
  logic [3:0]          aw_region;
  logic [3:0]          aw_qos;
  logic [USER_W-1:0]   aw_user;
  logic                aw_valid;
  logic                aw_ready;

  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                w_last;
  logic [USER_W-1:0]   w_user;
  logic                w_valid;
  logic                w_ready;

  logic [ID_W-1:0]     b_id;
  logic [1:0]          b_resp;
  logic [USER_W-1:0]   b_user;
  logic                b_valid;
  logic                b_ready;

  logic [ID_W-1:0]     ar_id;
  logic [ADDR_W-1:0]   ar_addr;
  logic [7:0]          ar_len;
  logic [2:0]          ar_size;
  logic [1:0]          ar_burst;
  logic                ar_lock;
  logic [3:0]          ar_cache;
  logic [2:0]          ar_prot;
  logic [3:0]          ar_region;
  logic [3:0]          ar_qos;
  logic [USER_W-1:0]   ar_user;
  logic                ar_valid;
  logic                ar_ready;

  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_resp;
  logic                r_last;
  logic [USER_W-1:0]   r_user;
  logic                r_valid;
  logic                r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_region, aw_qos, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_region, ar_qos, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_region, aw_qos, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_region, ar_qos, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/core2axi_mo.sv
// rtl/core2axi_mo.sv - core req/gnt to single-beat AXI4 bridge with in-order outstanding tracking.
// Optional error output enabled by CORE2AXI_MO_ERR_EN.
module core2axi_mo #(
  parameter int AXI4_ADDRESS_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH    = 64,
  parameter int AXI4_ID_WIDTH      = 4,
  parameter int AXI4_USER_WIDTH    = 10,
  parameter int MAX_OUTSTANDING    = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          data_req_i,
  output logic                          data_gnt_o,
  input  logic [AXI4_ADDRESS_WIDTH-1:0] data_addr_i,
  input  logic                          data_we_i,
  input  logic [3:0]                    data_be_i,
  input  logic [31:0]                   data_wdata_i,
  output logic                          data_rvalid_o,
  output logic [31:0]                   data_rdata_o,
`ifdef CORE2AXI_MO_ERR_EN
  output logic                          data_err_o,
`endif
  core2axi_mo_if.master                 axi
);
  localparam int LANE_W  = $clog2(AXI4_DATA_WIDTH / 8) - 2;
  localparam int LANE_SZ = (LANE_W > 0) ? LANE_W : 1;
  localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  typedef enum logic [1:0] {ISSUE, W_ONLY, AW_ONLY} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               cur_we;
  logic               fifo_we   [MAX_OUTSTANDING];
  logic [LANE_SZ-1:0] fifo_lane [MAX_OUTSTANDING];
  logic [LANE_SZ-1:0] req_lane, head_lane;
  logic               head_we, fifo_nempty;
  logic               can_issue, gnt, r_hs, b_hs, pop;
  logic [AXI4_DATA_WIDTH/8-1:0] strb;
  logic               unused_inputs;

  generate
    if (LANE_W > 0) begin : g_lane
      assign req_lane = data_addr_i[LANE_W+1:2];
    end else begin : g_nolane
      assign req_lane = 1'b0;
    end
  endgenerate

  assign axi.aw_id     = '0;
  assign axi.aw_addr   = data_addr_i;
  assign axi.aw_len    = 8'd0;
  assign axi.aw_size   = 3'b010;
  assign axi.aw_burst  = 2'b01;
  assign axi.aw_lock   = 1'b0;
  assign axi.aw_cache  = 4'd0;
  assign axi.aw_prot   = 3'd0;
  assign axi.aw_region = 4'd0;
  assign axi.aw_qos    = 4'd0;
  assign axi.aw_user   = '0;
  assign axi.ar_id     = '0;
  assign axi.ar_addr   = data_addr_i;
  assign axi.ar_len    = 8'd0;
  assign axi.ar_size   = 3'b010;
  assign axi.ar_burst  = 2'b01;
  assign axi.ar_lock   = 1'b0;
  assign axi.ar_cache  = 4'd0;
  assign axi.ar_prot   = 3'd0;
  assign axi.ar_region = 4'd0;
  assign axi.ar_qos    = 4'd0;
  assign axi.ar_user   = '0;
  assign axi.w_last    = 1'b1;
  assign axi.w_user    = '0;
  assign axi.w_data    = {(AXI4_DATA_WIDTH/32){data_wdata_i}};

  always_comb begin
    strb = '0;
    strb[4*req_lane +: 4] = data_be_i;
  end
  assign axi.w_strb = strb;

  // Single ID: mixing reads and writes in flight could reorder responses, so a type switch drains first.
  assign can_issue = (cnt < CNT_MAX) && ((cnt == '0) || (data_we_i == cur_we));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ISSUE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ISSUE: begin
        if (data_req_i && can_issue && data_we_i) begin
          if (axi.aw_ready && !axi.w_ready)      state_nxt = W_ONLY;
          else if (!axi.aw_ready && axi.w_ready) state_nxt = AW_ONLY;
        end
      end
      W_ONLY:  if (axi.w_ready)  state_nxt = ISSUE;
      AW_ONLY: if (axi.aw_ready) state_nxt = ISSUE;
      default: state_nxt = ISSUE;
    endcase
  end

  always_comb begin
    axi.ar_valid = 1'b0;
    axi.aw_valid = 1'b0;
    axi.w_valid  = 1'b0;
    gnt          = 1'b0;
    case (state)
      ISSUE: begin
        if (data_req_i && can_issue) begin
          if (data_we_i) begin
            axi.aw_valid = 1'b1;
            axi.w_valid  = 1'b1;
            gnt          = axi.aw_ready && axi.w_ready;
          end else begin
            axi.ar_valid = 1'b1;
            gnt          = axi.ar_ready;
          end
        end
      end
      W_ONLY: begin
        axi.w_valid = 1'b1;
        gnt         = axi.w_ready;
      end
      AW_ONLY: begin
        axi.aw_valid = 1'b1;
        gnt          = axi.aw_ready;
      end
      default: ;
    endcase
  end
  assign data_gnt_o = gnt;

  assign fifo_nempty = (cnt != '0);
  assign head_we     = fifo_we[rd_ptr];
  assign head_lane   = fifo_lane[rd_ptr];
  assign axi.r_ready = fifo_nempty && !head_we;
  assign axi.b_ready = fifo_nempty && head_we;
  assign r_hs        = axi.r_valid && axi.r_ready;
  assign b_hs        = axi.b_valid && axi.b_ready;
  assign pop         = r_hs || b_hs;

  assign data_rvalid_o = pop;
  assign data_rdata_o  = r_hs ? axi.r_data[32*head_lane +: 32] : 32'd0;

`ifdef CORE2AXI_MO_ERR_EN
  assign data_err_o = (r_hs && axi.r_resp[1]) || (b_hs && axi.b_resp[1]);
  assign unused_inputs = ^{axi.r_last, axi.r_id, axi.r_user, axi.b_id, axi.b_user};
`else
  assign unused_inputs = ^{axi.r_last, axi.r_id, axi.r_user, axi.b_id, axi.b_user,
                           axi.r_resp, axi.b_resp};
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cur_we <= 1'b0;
    end else begin
      if (gnt) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        cur_we <= data_we_i;
      end
      if (pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      if (gnt && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !gnt) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (gnt) begin
      fifo_we[wr_ptr]   <= data_we_i;
      fifo_lane[wr_ptr] <= req_lane;
    end
  end
endmodule

// File: tb/tb_core2axi_mo.sv
// tb/tb_core2axi_mo.sv - directed self-checking bench for core2axi_mo (DW=64, MAX_OUTSTANDING=4).
module tb_core2axi_mo;
  logic        clk = 1'b0;
  logic        rst;
  logic        req, gnt, we, rvalid;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
`ifdef CORE2AXI_MO_ERR_EN
  logic        err;
`endif
  int checks = 0;
  int failures = 0;

  core2axi_mo_if #(.ADDR_W(32), .DATA_W(64), .ID_W(4), .USER_W(10)) axi ();

  core2axi_mo #(
    .AXI4_ADDRESS_WIDTH(32), .AXI4_DATA_WIDTH(64), .AXI4_ID_WIDTH(4),
    .AXI4_USER_WIDTH(10), .MAX_OUTSTANDING(4)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .data_req_i(req), .data_gnt_o(gnt), .data_addr_i(addr), .data_we_i(we),
    .data_be_i(be), .data_wdata_i(wdata), .data_rvalid_o(rvalid), .data_rdata_o(rdata),
`ifdef CORE2AXI_MO_ERR_EN
    .data_err_o(err),
`endif
    .axi(axi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_rd [4];

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0;
    axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.ar_ready = 1'b0;
    axi.b_valid = 1'b0; axi.b_resp = 2'b00; axi.b_id = '0; axi.b_user = '0;
    axi.r_valid = 1'b0; axi.r_data = '0; axi.r_resp = 2'b00; axi.r_last = 1'b1;
    axi.r_id = '0; axi.r_user = '0;
    cyc(); cyc();

    check("rst_gnt", gnt, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_ar_valid", axi.ar_valid, 0);
    check("rst_aw_valid", axi.aw_valid, 0);
    check("rst_w_valid", axi.w_valid, 0);
    check("rst_r_ready", axi.r_ready, 0);
    check("rst_b_ready", axi.b_ready, 0);
    check("const_ar_size", axi.ar_size, 3'b010);
    check("const_aw_burst", axi.aw_burst, 2'b01);
    check("const_w_last", axi.w_last, 1);
    check("const_aw_len", axi.aw_len, 0);
    rst = 1'b0;
    cyc();

    // Four back-to-back reads, fifth stalls at full
    req = 1'b1; we = 1'b0; axi.ar_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = 32'(i * 4);
      #1;
      check("rd_ar_valid", axi.ar_valid, 1);
      check("rd_gnt", gnt, 1);
      check("rd_ar_addr", axi.ar_addr, 32'(i * 4));
      cyc();
    end
    addr = 32'h10;
    #1;
    check("full_gnt", gnt, 0);
    check("full_ar_valid", axi.ar_valid, 0);
    req = 1'b0; axi.ar_ready = 1'b0;
    repeat (4) cyc();

    exp_rd[0] = 32'h33334444; exp_rd[1] = 32'h11112222;
    exp_rd[2] = 32'h33334444; exp_rd[3] = 32'h11112222;
    axi.r_valid = 1'b1; axi.r_data = 64'h11112222_33334444;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rd_r_ready", axi.r_ready, 1);
      check("rd_rvalid", rvalid, 1);
      check("rd_rdata", rdata, exp_rd[i]);
      cyc();
    end
    #1;
    check("rd_empty_r_ready", axi.r_ready, 0);
    check("rd_empty_rvalid", rvalid, 0);
    axi.r_valid = 1'b0;
    cyc();

    // Write: AW accepted first, W two cycles later
    req = 1'b1; we = 1'b1; addr = 32'h4; be = 4'b0011; wdata = 32'hA5A50F0F;
    axi.aw_ready = 1'b1; axi.w_ready = 1'b0;
    #1;
    check("wr_aw_valid", axi.aw_valid, 1);
    check("wr_w_valid", axi.w_valid, 1);
    check("wr_strb", axi.w_strb, 8'b0011_0000);
    check("wr_data", axi.w_data, 64'hA5A50F0F_A5A50F0F);
    check("wr_gnt_aw", gnt, 0);
    cyc();
    axi.aw_ready = 1'b0;
    #1;
    check("wonly_aw_valid", axi.aw_valid, 0);
    check("wonly_w_valid", axi.w_valid, 1);
    check("wonly_gnt_wait", gnt, 0);
    cyc();
    axi.w_ready = 1'b1;
    #1;
    check("wonly_gnt", gnt, 1);
    cyc();
    req = 1'b0; axi.w_ready = 1'b0; axi.b_valid = 1'b1;
    #1;
    check("wr_b_ready", axi.b_ready, 1);
    check("wr_rvalid", rvalid, 1);
    check("wr_rdata", rdata, 0);
    cyc();
    axi.b_valid = 1'b0;
    #1;
    check("wr_rvalid_once", rvalid, 0);

    // Write: W accepted first, then AW
    req = 1'b1; we = 1'b1; addr = 32'h0; be = 4'b1111; axi.w_ready = 1'b1;
    #1;
    check("aw_only_gnt_w", gnt, 0);
    check("aw_only_strb", axi.w_strb, 8'h0F);
    cyc();
    axi.w_ready = 1'b0; axi.aw_ready = 1'b1;
    #1;
    check("aw_only_aw_valid", axi.aw_valid, 1);
    check("aw_only_w_valid", axi.w_valid, 0);
    check("aw_only_gnt", gnt, 1);
    cyc();
    req = 1'b0; axi.aw_ready = 1'b0; axi.b_valid = 1'b1;
    #1;
    check("aw_only_rvalid", rvalid, 1);
    cyc();
    axi.b_valid = 1'b0;

    // Read in flight blocks a write until drained
    req = 1'b1; we = 1'b0; addr = 32'h8; axi.ar_ready = 1'b1;
    #1;
    check("sw_rd_gnt", gnt, 1);
    cyc();
    we = 1'b1; addr = 32'h0; be = 4'hF; axi.ar_ready = 1'b0;
    axi.aw_ready = 1'b1; axi.w_ready = 1'b1;
    #1;
    check("sw_aw_valid_stall", axi.aw_valid, 0);
    check("sw_w_valid_stall", axi.w_valid, 0);
    check("sw_gnt_stall", gnt, 0);
    cyc();
    axi.r_valid = 1'b1; axi.r_data = 64'hDEADBEEF_CAFEF00D;
    #1;
    check("sw_rvalid", rvalid, 1);
    check("sw_rdata", rdata, 32'hCAFEF00D);
    check("sw_gnt_prepop", gnt, 0);
    cyc();
    axi.r_valid = 1'b0;
    #1;
    check("sw_aw_valid", axi.aw_valid, 1);
    check("sw_gnt", gnt, 1);
    cyc();
    req = 1'b0; axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.b_valid = 1'b1;
    #1;
    check("sw_b_rvalid", rvalid, 1);
    cyc();
    axi.b_valid = 1'b0;

    // Grant and response in the same cycle at cnt == 2
    req = 1'b1; we = 1'b0; axi.ar_ready = 1'b1; addr = 32'h0;
    #1;
    check("mix_gnt0", gnt, 1);
    cyc();
    addr = 32'h4;
    #1;
    check("mix_gnt1", gnt, 1);
    cyc();
    addr = 32'h8; axi.r_valid = 1'b1; axi.r_data = 64'hAAAABBBB_CCCCDDDD;
    #1;
    check("mix_gnt2", gnt, 1);
    check("mix_rvalid", rvalid, 1);
    check("mix_rdata0", rdata, 32'hCCCCDDDD);
    cyc();
    req = 1'b0; axi.ar_ready = 1'b0;
    #1;
    check("mix_rdata1", rdata, 32'hAAAABBBB);
    cyc();
    #0;
    check("mix_rdata2", rdata, 32'hCCCCDDDD);
    check("mix_rvalid2", rvalid, 1);
    cyc();
    check("mix_empty_r_ready", axi.r_ready, 0);
    check("mix_empty_rvalid", rvalid, 0);
    axi.r_valid = 1'b0;
    cyc();

    // Reset with three reads outstanding
    req = 1'b1; we = 1'b0; axi.ar_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr = 32'(i * 4);
      #1;
      check("mrst_gnt", gnt, 1);
      cyc();
    end
    req = 1'b0; axi.ar_ready = 1'b0; rst = 1'b1;
    cyc();
    check("mrst_r_ready", axi.r_ready, 0);
    check("mrst_gnt_after", gnt, 0);
    check("mrst_rvalid", rvalid, 0);
    rst = 1'b0;
    axi.r_valid = 1'b1; axi.r_data = 64'h12345678_9ABCDEF0;
    #1;
    check("late_r_ready", axi.r_ready, 0);
    check("late_rvalid", rvalid, 0);
    check("late_rdata", rdata, 0);
    cyc();
    axi.r_valid = 1'b0;

    // Write responses with SLVERR then OKAY
    for (int k = 0; k < 2; k++) begin
      req = 1'b1; we = 1'b1; addr = 32'h0; be = 4'hF;
      axi.aw_ready = 1'b1; axi.w_ready = 1'b1;
      #1;
      check("err_wr_gnt", gnt, 1);
      cyc();
      req = 1'b0; axi.aw_ready = 1'b0; axi.w_ready = 1'b0;
      axi.b_valid = 1'b1; axi.b_resp = (k == 0) ? 2'b10 : 2'b00;
      #1;
      check("err_rvalid", rvalid, 1);
`ifdef CORE2AXI_MO_ERR_EN
      check("err_flag", err, (k == 0) ? 1'b1 : 1'b0);
`endif
      cyc();
      axi.b_valid = 1'b0; axi.b_resp = 2'b00;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
